// File: rtl/piso_word_serializer_pkg.sv
// piso_word_serializer_pkg: shared state encoding and counter-width helper for the serializer
package piso_word_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n)
                r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/piso_word_serializer_hold_reg.sv
// serializer_hold_reg: one-word holding register with valid flag, write-enable and clear
module serializer_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             v
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
            v <= 1'b0;
        end else if (we) begin
            q <= d;
            v <= 1'b1;
        end else if (clr) begin
            v <= 1'b0;
        end
    end

endmodule

// File: rtl/piso_word_serializer.sv
// piso_word_serializer: parallel-in/serial-out word serializer with a one-word holding register
module piso_word_serializer
    import piso_word_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    cnt;
    logic             hold_v;
    logic             xfer;
    logic             last;

    assign last      = cnt == CW'(WIDTH - 1);
    assign din_ready = state == ST_IDLE || !hold_v;
    assign xfer      = din_valid && din_ready;
    assign shifted   = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    // sreg is zeroed when idle, so sout reads 0 whenever no word is in flight
    assign sout      = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

    serializer_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk (clk),
        .rst (rst),
        .we  (xfer && state == ST_SHIFT && !last),
        .clr (state == ST_SHIFT && last && hold_v),
        .d   (din),
        .q   (hold),
        .v   (hold_v)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            sreg        <= '0;
            cnt         <= '0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (xfer) begin
                state       <= ST_SHIFT;
                sreg        <= din;
                cnt         <= '0;
                sout_valid  <= 1'b1;
                frame_start <= 1'b1;
                busy        <= 1'b1;
            end
        end else if (!last) begin
            sreg        <= shifted;
            cnt         <= cnt + 1'b1;
            frame_start <= 1'b0;
        end else if (hold_v) begin
            sreg        <= hold;
            cnt         <= '0;
            frame_start <= 1'b1;
        end else if (xfer) begin
            sreg        <= din;
            cnt         <= '0;
            frame_start <= 1'b1;
        end else begin
            state       <= ST_IDLE;
            sreg        <= '0;
            cnt         <= '0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end
    end

endmodule
